rgmii_rx_ctrl: RTL and testbench
================================

RGMII_RX_CTRL -- requirements
Module: rgmii_rx_ctrl

Interface
REQ-001 SHALL have parameter STARTUP_CYCLES, default 16: cycles ClkEN is held low after reset release.
REQ-002 SHALL have parameter STATUS_STABLE, default 3: number of consecutive identical in-band status samples required before the status outputs update.
REQ-003 SHALL have parameter MAX_LEN, default 1522: maximum legal frame length in bytes, counted after the SFD.
REQ-004 SHALL have port RxClk, input, width 1: the single clock, the recovered RGMII receive clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-006 SHALL have port RxD, input, width 8: GMII receive byte from the RGMII-to-GMII converter.
REQ-007 SHALL have port RxDV, input, width 1: GMII receive data valid.
REQ-008 SHALL have port RxER, input, width 1: GMII receive error.
REQ-009 SHALL have port ClkEN, output, width 1: clock enable driven to the converter's DDR capture stage.
REQ-010 SHALL have outputs LinkUp (1 bit), Speed (2 bits) and Duplex (1 bit): decoded in-band status.
REQ-011 SHALL have outputs Data (8 bits) and DataValid (1 bit): frame payload with preamble and SFD stripped.
REQ-012 SHALL have outputs SOF (1 bit) and EOF (1 bit): single-cycle frame start and end strobes.
REQ-013 SHALL have outputs FrameErr (1 bit) and FrameLen (14 bits): frame status, valid only in the EOF cycle.
REQ-014 SHALL have output ErrCnt, width 16: saturating count of bad frames.

Function
REQ-015 SHALL implement FSM states HOLD, IDLE, PREAMBLE, DATA and DROP, and SHALL enter HOLD on reset.
REQ-016 HOLD: ClkEN=0 and a startup counter runs; after STARTUP_CYCLES cycles the FSM SHALL move to IDLE, and ClkEN SHALL be 1 from then on.
REQ-017 IDLE: RxDV=1 with RxD=0x55 SHALL go to PREAMBLE; RxDV=1 with any other byte SHALL go to DROP.
REQ-018 PREAMBLE: RxDV=1 with 0x55 SHALL stay; RxDV=1 with 0xD5 SHALL go to DATA; RxDV=1 with any other byte SHALL go to DROP; RxDV=0 SHALL go to IDLE, increment ErrCnt and emit no EOF.
REQ-019 DATA, each RxDV=1 cycle: Data=RxD and DataValid=1 SHALL appear 1 cycle later (latency 1); SOF SHALL accompany the first payload byte only.
REQ-020 DATA: the byte counter SHALL increment per payload byte and saturate at 16383.
REQ-021 DATA: a sticky error SHALL be set by RxER=1 while RxDV=1, or by the count exceeding MAX_LEN.
REQ-022 DATA: when RxDV=0 at cycle n, the FSM SHALL go to IDLE, and at n+1 EOF=1, DataValid=0, FrameLen=byte count and FrameErr=sticky error.
REQ-023 SFD followed immediately by RxDV=0 SHALL produce EOF with FrameLen=0, FrameErr=1 and no SOF.
REQ-024 DROP: ErrCnt SHALL increment on entry; the FSM SHALL stay until RxDV=0, then go to IDLE; no Data, SOF or EOF in DROP.
REQ-025 ErrCnt SHALL increment on every EOF with FrameErr=1, on every DROP entry and on every PREAMBLE abort, saturating at 0xFFFF.
REQ-026 In-band status, sampled only in IDLE with RxDV=0 and RxER=0: when RxD[3:0] equals the previous sample, a stability counter increments; otherwise it reloads to 1.
REQ-027 When the stability counter reaches STATUS_STABLE, the status outputs SHALL update next cycle: LinkUp=RxD[0], Speed=RxD[2:1] (00=10M, 01=100M, 10=1G), Duplex=RxD[3].
REQ-028 RxDV=0 with RxER=1 (carrier extension or false carrier) SHALL clear the stability counter; status outputs SHALL hold their values during frames.
REQ-029 SOF, EOF and DataValid SHALL never be asserted in the same cycle as each other.

Reset
REQ-030 With rst=1 at a clock edge, all outputs SHALL be 0 next cycle: ClkEN, LinkUp, Speed, Duplex, Data, DataValid, SOF, EOF, FrameErr, FrameLen and ErrCnt.
REQ-031 Reset SHALL also clear all counters and the previous-status register, and put the FSM in HOLD.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no EOF and no ErrCnt increment.
REQ-033 After reset the FSM SHALL ignore RxDV until HOLD completes; a frame already in progress at HOLD exit SHALL be sent to DROP if its current byte is not 0x55.

Verification
REQ-034 Release rst -> ClkEN=0 for 16 cycles, then 1 on cycle 17.
REQ-035 Idle RxD=0x0D for 3 cycles (DV=0, ER=0) -> LinkUp=1, Speed=10, Duplex=1; alternating 0x0D/0x0B -> no update.
REQ-036 7x0x55, 0xD5, 64 bytes, then DV=0 -> SOF with byte 1, 64 DataValid cycles, EOF with FrameLen=64, FrameErr=0, ErrCnt=0.
REQ-037 Same frame with RxER=1 on byte 10 -> FrameErr=1 at EOF, FrameLen=64, ErrCnt=1.
REQ-038 1600-byte frame -> FrameErr=1, FrameLen=1600; frame starting 0xAA -> DROP, no SOF/EOF, ErrCnt+1.
REQ-039 rst asserted at payload byte 20 -> no EOF, all outputs 0 next cycle, ErrCnt=0.

Source files
------------

// File: rtl/rgmii_rx_ctrl.sv
// RGMII receive controller: startup clock-enable hold, in-band link status decode,
// preamble/SFD stripping with frame length/error reporting, and a bad-frame counter.
module rgmii_rx_ctrl #(
   parameter int STARTUP_CYCLES = 16,
   parameter int STATUS_STABLE  = 3,
   parameter int MAX_LEN        = 1522
) (
   input  logic        RxClk,
   input  logic        rst,
   input  logic [7:0]  RxD,
   input  logic        RxDV,
   input  logic        RxER,
   output logic        ClkEN,
   output logic        LinkUp,
   output logic [1:0]  Speed,
   output logic        Duplex,
   output logic [7:0]  Data,
   output logic        DataValid,
   output logic        SOF,
   output logic        EOF,
   output logic        FrameErr,
   output logic [13:0] FrameLen,
   output logic [15:0] ErrCnt
);

   localparam int SW  = (STARTUP_CYCLES < 1) ? 1 : $clog2(STARTUP_CYCLES + 1);
   localparam int STW = (STATUS_STABLE < 1) ? 1 : $clog2(STATUS_STABLE + 1);

   localparam logic [SW-1:0]  STARTUP_LAST = SW'(STARTUP_CYCLES);
   localparam logic [STW-1:0] STABLE_LAST  = STW'(STATUS_STABLE);
   localparam logic [13:0]    MAX_LEN_C    = 14'(MAX_LEN);
   localparam logic [13:0]    LEN_SAT      = 14'h3FFF;
   localparam logic [15:0]    ERR_SAT      = 16'hFFFF;
   localparam logic [7:0]     PRE_BYTE     = 8'h55;
   localparam logic [7:0]     SFD_BYTE     = 8'hD5;

   typedef enum logic [2:0] {HOLD, IDLE, PREAMBLE, DATA, DROP} state_t;

   state_t         state_q, state_d;
   logic [SW-1:0]  startup_q, startup_d;
   logic [STW-1:0] stab_q, stab_d;
   logic [3:0]     prev_q, prev_d;
   logic [13:0]    len_q, len_d;
   logic           err_q, err_d;
   logic           clken_q, clken_d;
   logic           link_q, link_d;
   logic [1:0]     speed_q, speed_d;
   logic           duplex_q, duplex_d;
   logic [7:0]     data_q, data_d;
   logic           dv_q, dv_d;
   logic           sof_q, sof_d;
   logic           eof_q, eof_d;
   logic           ferr_q, ferr_d;
   logic [13:0]    flen_q, flen_d;
   logic [15:0]    errcnt_q, errcnt_d;
   logic           bump_err;

   always_comb begin
      // NOTE: every _d is given a default first so no path through the case infers a latch.
      state_d   = state_q;
      startup_d = startup_q;
      stab_d    = stab_q;
      prev_d    = prev_q;
      len_d     = len_q;
      err_d     = err_q;
      clken_d   = clken_q;
      link_d    = link_q;
      speed_d   = speed_q;
      duplex_d  = duplex_q;
      data_d    = data_q;
      dv_d      = 1'b0;
      sof_d     = 1'b0;
      eof_d     = 1'b0;
      ferr_d    = 1'b0;
      flen_d    = '0;
      bump_err  = 1'b0;

      // Carrier extension / false carrier invalidates any status run in progress.
      if (!RxDV && RxER) stab_d = '0;

      case (state_q)
         HOLD: begin
            if (startup_q == STARTUP_LAST) begin
               state_d = IDLE;
               clken_d = 1'b1;
            end else begin
               startup_d = startup_q + 1'b1;
            end
         end

         IDLE: begin
            if (RxDV) begin
               if (RxD == PRE_BYTE) begin
                  state_d = PREAMBLE;
               end else begin
                  state_d  = DROP;
                  bump_err = 1'b1;
               end
            end else if (!RxER) begin
               prev_d = RxD[3:0];
               if (RxD[3:0] == prev_q)
                  stab_d = (stab_q == STABLE_LAST) ? stab_q : stab_q + 1'b1;
               else
                  stab_d = STW'(1);
               if (stab_d == STABLE_LAST) begin
                  link_d   = RxD[0];
                  speed_d  = RxD[2:1];
                  duplex_d = RxD[3];
               end
            end
         end

         PREAMBLE: begin
            if (!RxDV) begin
               state_d  = IDLE;
               bump_err = 1'b1;
            end else if (RxD == SFD_BYTE) begin
               state_d = DATA;
               len_d   = '0;
               err_d   = 1'b0;
            end else if (RxD != PRE_BYTE) begin
               state_d  = DROP;
               bump_err = 1'b1;
            end
         end

         DATA: begin
            if (RxDV) begin
               dv_d   = 1'b1;
               data_d = RxD;
               sof_d  = (len_q == '0);
               len_d  = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;
               if (RxER || (len_d > MAX_LEN_C)) err_d = 1'b1;
            end else begin
               // An empty payload (SFD then end of frame) is reported as a bad frame.
               state_d  = IDLE;
               eof_d    = 1'b1;
               flen_d   = len_q;
               ferr_d   = err_q || (len_q == '0);
               bump_err = ferr_d;
            end
         end

         DROP: begin
            if (!RxDV) state_d = IDLE;
         end

         default: state_d = HOLD;
      endcase

      errcnt_d = (bump_err && (errcnt_q != ERR_SAT)) ? errcnt_q + 1'b1 : errcnt_q;
   end

   always_ff @(posedge RxClk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
      if (rst) begin
         state_q   <= HOLD;
         startup_q <= '0;
         stab_q    <= '0;
         prev_q    <= '0;
         len_q     <= '0;
         err_q     <= 1'b0;
         clken_q   <= 1'b0;
         link_q    <= 1'b0;
         speed_q   <= '0;
         duplex_q  <= 1'b0;
         data_q    <= '0;
         dv_q      <= 1'b0;
         sof_q     <= 1'b0;
         eof_q     <= 1'b0;
         ferr_q    <= 1'b0;
         flen_q    <= '0;
         errcnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         startup_q <= startup_d;
         stab_q    <= stab_d;
         prev_q    <= prev_d;
         len_q     <= len_d;
         err_q     <= err_d;
         clken_q   <= clken_d;
         link_q    <= link_d;
         speed_q   <= speed_d;
         duplex_q  <= duplex_d;
         data_q    <= data_d;
         dv_q      <= dv_d;
         sof_q     <= sof_d;
         eof_q     <= eof_d;
         ferr_q    <= ferr_d;
         flen_q    <= flen_d;
         errcnt_q  <= errcnt_d;
      end
   end

   assign ClkEN     = clken_q;
   assign LinkUp    = link_q;
   assign Speed     = speed_q;
   assign Duplex    = duplex_q;
   assign Data      = data_q;
   assign DataValid = dv_q;
   assign SOF       = sof_q;
   assign EOF       = eof_q;
   assign FrameErr  = ferr_q;
   assign FrameLen  = flen_q;
   assign ErrCnt    = errcnt_q;

endmodule

// File: tb/tb_rgmii_rx_ctrl.sv
// Self-checking bench for rgmii_rx_ctrl: frame-level transaction generator that
// predicts every output cycle, a per-cycle compare process, and literal pins.
module tb_rgmii_rx_ctrl;

   localparam int STARTUP = 16;
   localparam int STABLE  = 3;
   localparam int MAXL    = 1522;

   logic        RxClk = 1'b0;
   logic        rst;
   logic [7:0]  RxD;
   logic        RxDV;
   logic        RxER;
   logic        ClkEN;
   logic        LinkUp;
   logic [1:0]  Speed;
   logic        Duplex;
   logic [7:0]  Data;
   logic        DataValid;
   logic        SOF;
   logic        EOF;
   logic        FrameErr;
   logic [13:0] FrameLen;
   logic [15:0] ErrCnt;

   always #5 RxClk = ~RxClk;

   rgmii_rx_ctrl #(
      .STARTUP_CYCLES(STARTUP),
      .STATUS_STABLE (STABLE),
      .MAX_LEN       (MAXL)
   ) dut (
      .RxClk    (RxClk),
      .rst      (rst),
      .RxD      (RxD),
      .RxDV     (RxDV),
      .RxER     (RxER),
      .ClkEN    (ClkEN),
      .LinkUp   (LinkUp),
      .Speed    (Speed),
      .Duplex   (Duplex),
      .Data     (Data),
      .DataValid(DataValid),
      .SOF      (SOF),
      .EOF      (EOF),
      .FrameErr (FrameErr),
      .FrameLen (FrameLen),
      .ErrCnt   (ErrCnt)
   );

   typedef struct {
      logic        is_rst;
      logic        clken;
      logic        link;
      logic [1:0]  speed;
      logic        duplex;
      logic        dv;
      logic [7:0]  data;
      logic        sof;
      logic        eof;
      logic        ferr;
      logic [13:0] flen;
      logic [15:0] errcnt;
   } exp_t;

   exp_t expq[$];
   exp_t ce;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: bad-frame count, link status and the stability run.
   int         m_errcnt;
   logic       m_clken;
   logic       m_link;
   logic [1:0] m_speed;
   logic       m_duplex;
   logic [3:0] st_prev;
   int         st_run;

   int obs_dv, obs_sof, obs_eof, obs_flen, obs_ferr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t quiet();
      exp_t e;
      e.is_rst = 1'b0;
      e.clken  = 1'b0;
      e.link   = 1'b0;
      e.speed  = 2'b00;
      e.duplex = 1'b0;
      e.dv     = 1'b0;
      e.data   = 8'h00;
      e.sof    = 1'b0;
      e.eof    = 1'b0;
      e.ferr   = 1'b0;
      e.flen   = 14'h0;
      e.errcnt = 16'h0;
      return e;
   endfunction

   task automatic bump_err();
      if (m_errcnt < 65535) m_errcnt++;
   endtask

   // One clock: drive inputs, predict outputs after the edge, return just past the negedge.
   task automatic tick(input logic r, input logic [7:0] d, input logic dv, input logic er,
                       input exp_t e_in);
      exp_t e;
      e = e_in;
      rst  = r;
      RxD  = d;
      RxDV = dv;
      RxER = er;
      if (!r && !dv && er) st_run = 0;
      e.clken  = m_clken;
      e.link   = m_link;
      e.speed  = m_speed;
      e.duplex = m_duplex;
      e.errcnt = 16'(m_errcnt);
      @(posedge RxClk);
      #1;
      expq.push_back(e);
      @(negedge RxClk);
      #1;
   endtask

   task automatic do_reset();
      exp_t e;
      m_errcnt = 0;
      m_clken  = 1'b0;
      m_link   = 1'b0;
      m_speed  = 2'b00;
      m_duplex = 1'b0;
      st_prev  = 4'h0;
      st_run   = 0;
      e = quiet();
      e.is_rst = 1'b1;
      tick(1'b1, 8'($urandom), 1'($urandom), 1'($urandom), e);
   endtask

   task automatic hold_phase(input bit tail_aa);
      for (int k = 1; k <= STARTUP + 1; k++) begin
         if (k == STARTUP + 1) m_clken = 1'b1;
         if (tail_aa) tick(1'b0, 8'hAA, 1'b1, 1'b0, quiet());
         else         tick(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), quiet());
      end
   endtask

   task automatic idle_cycle(input logic [3:0] nib, input logic er);
      if (!er) begin
         if (nib == st_prev) st_run = (st_run < STABLE) ? st_run + 1 : STABLE;
         else                st_run = 1;
         st_prev = nib;
         if (st_run == STABLE) begin
            m_link   = nib[0];
            m_speed  = nib[2:1];
            m_duplex = nib[3];
         end
      end
      tick(1'b0, {4'($urandom), nib}, 1'b0, er, quiet());
   endtask

   task automatic send_frame(input int n_pre, input int len, input int er_pos,
                             input bit noisy, input int cut);
      exp_t       e;
      logic [7:0] b;
      logic       er;
      bit         bad;
      for (int i = 0; i < n_pre; i++)
         tick(1'b0, 8'h55, 1'b1, noisy && ($urandom_range(0, 3) == 0), quiet());
      tick(1'b0, 8'hD5, 1'b1, noisy && ($urandom_range(0, 3) == 0), quiet());
      bad = (len == 0) || (len > MAXL);
      for (int i = 0; i < len; i++) begin
         if (i == cut) return;
         b  = 8'($urandom);
         er = (i == er_pos) || (noisy && ($urandom_range(0, 49) == 0));
         if (er) bad = 1'b1;
         e = quiet();
         e.dv   = 1'b1;
         e.data = b;
         e.sof  = (i == 0);
         tick(1'b0, b, 1'b1, er, e);
      end
      e = quiet();
      e.eof  = 1'b1;
      e.flen = (len > 16383) ? 14'h3FFF : 14'(len);
      e.ferr = bad;
      if (bad) bump_err();
      tick(1'b0, 8'($urandom), 1'b0, noisy && ($urandom_range(0, 3) == 0), e);
   endtask

   task automatic drop_tail(input int n_tail);
      for (int i = 0; i < n_tail; i++)
         tick(1'b0, 8'($urandom), 1'b1, 1'($urandom), quiet());
      tick(1'b0, 8'($urandom), 1'b0, 1'($urandom), quiet());
   endtask

   task automatic drop_frame(input logic [7:0] lead, input int n_tail);
      bump_err();
      tick(1'b0, lead, 1'b1, 1'b0, quiet());
      drop_tail(n_tail);
   endtask

   task automatic pre_bad(input int n_pre, input int n_tail);
      logic [7:0] b;
      for (int i = 0; i < n_pre; i++) tick(1'b0, 8'h55, 1'b1, 1'b0, quiet());
      do b = 8'($urandom); while (b == 8'h55 || b == 8'hD5);
      bump_err();
      tick(1'b0, b, 1'b1, 1'b0, quiet());
      drop_tail(n_tail);
   endtask

   task automatic pre_abort(input int n_pre);
      for (int i = 0; i < n_pre; i++) tick(1'b0, 8'h55, 1'b1, 1'b0, quiet());
      bump_err();
      tick(1'b0, 8'($urandom), 1'b0, 1'($urandom), quiet());
   endtask

   task automatic idle_burst();
      int         n;
      logic [3:0] nib;
      n   = $urandom_range(1, 6);
      nib = 4'($urandom);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 7) == 0) idle_cycle(4'($urandom), 1'b0);
         else                           idle_cycle(nib, ($urandom_range(0, 9) == 0));
      end
   endtask

   task automatic clear_obs();
      obs_dv   = 0;
      obs_sof  = 0;
      obs_eof  = 0;
      obs_flen = -1;
      obs_ferr = -1;
   endtask

   always @(negedge RxClk) begin
      if (expq.size() > 0) begin
         ce = expq.pop_front();
         check("clken",  32'(ClkEN),     32'(ce.clken));
         check("link",   32'(LinkUp),    32'(ce.link));
         check("speed",  32'(Speed),     32'(ce.speed));
         check("duplex", 32'(Duplex),    32'(ce.duplex));
         check("dv",     32'(DataValid), 32'(ce.dv));
         check("sof",    32'(SOF),       32'(ce.sof));
         check("eof",    32'(EOF),       32'(ce.eof));
         check("errcnt", 32'(ErrCnt),    32'(ce.errcnt));
         if (ce.dv || ce.is_rst) check("data", 32'(Data), 32'(ce.data));
         if (ce.eof || ce.is_rst) begin
            check("frame_len", 32'(FrameLen), 32'(ce.flen));
            check("frame_err", 32'(FrameErr), 32'(ce.ferr));
         end
         if (DataValid === 1'b1) obs_dv++;
         if (SOF === 1'b1) obs_sof++;
         if (EOF === 1'b1) begin
            obs_eof++;
            obs_flen = int'(FrameLen);
            obs_ferr = int'(FrameErr);
         end
      end
   end

   initial begin
      #950_000;
      $display("FAIL watchdog: time limit reached before the end of stimulus");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int kind;
      int len;
      logic [7:0] b;
      rst  = 1'b1;
      RxD  = 8'h00;
      RxDV = 1'b0;
      RxER = 1'b0;
      clear_obs();
      @(negedge RxClk);
      #1;

      // Startup: ClkEN low for 16 cycles after release, high on the 17th.
      do_reset();
      check("lit_reset_clken", 32'(ClkEN), 0);
      hold_phase(1'b0);
      check("lit_clken_up", 32'(ClkEN), 1);

      // Stable 0x0D decodes to link up, 1G, full duplex; alternating values never settle.
      repeat (3) idle_cycle(4'hD, 1'b0);
      check("lit_link",   32'(LinkUp), 1);
      check("lit_speed",  32'(Speed),  2);
      check("lit_duplex", 32'(Duplex), 1);
      for (int i = 0; i < 6; i++) idle_cycle((i % 2 == 0) ? 4'hB : 4'hD, 1'b0);
      check("lit_speed_alt", 32'(Speed), 2);

      clear_obs();
      send_frame(7, 64, -1, 1'b0, -1);
      check("lit_good_sof",  32'(obs_sof),  1);
      check("lit_good_dv",   32'(obs_dv),   64);
      check("lit_good_eof",  32'(obs_eof),  1);
      check("lit_good_len",  32'(obs_flen), 64);
      check("lit_good_ferr", 32'(obs_ferr), 0);
      check("lit_good_cnt",  32'(ErrCnt),   0);

      clear_obs();
      send_frame(7, 64, 9, 1'b0, -1);
      check("lit_rxer_ferr", 32'(obs_ferr), 1);
      check("lit_rxer_len",  32'(obs_flen), 64);
      check("lit_rxer_cnt",  32'(ErrCnt),   1);

      clear_obs();
      send_frame(7, 1600, -1, 1'b0, -1);
      check("lit_long_ferr", 32'(obs_ferr), 1);
      check("lit_long_len",  32'(obs_flen), 1600);
      check("lit_long_cnt",  32'(ErrCnt),   2);

      clear_obs();
      drop_frame(8'hAA, 10);
      check("lit_drop_sof", 32'(obs_sof), 0);
      check("lit_drop_eof", 32'(obs_eof), 0);
      check("lit_drop_dv",  32'(obs_dv),  0);
      check("lit_drop_cnt", 32'(ErrCnt),  3);

      // Reset on payload byte 20 aborts silently; a frame still running at HOLD exit drops.
      clear_obs();
      send_frame(7, 64, -1, 1'b0, 19);
      do_reset();
      check("lit_mid_rst_eof", 32'(obs_eof),   0);
      check("lit_mid_rst_cnt", 32'(ErrCnt),    0);
      check("lit_mid_rst_dv",  32'(DataValid), 0);
      hold_phase(1'b1);
      drop_frame(8'hAA, 4);
      check("lit_hold_exit_drop", 32'(ErrCnt), 1);

      clear_obs();
      send_frame(1, 0, -1, 1'b0, -1);
      check("lit_empty_sof",  32'(obs_sof),  0);
      check("lit_empty_len",  32'(obs_flen), 0);
      check("lit_empty_ferr", 32'(obs_ferr), 1);

      clear_obs();
      send_frame(3, MAXL, -1, 1'b0, -1);
      check("lit_maxlen_ferr", 32'(obs_ferr), 0);
      clear_obs();
      send_frame(3, MAXL + 1, -1, 1'b0, -1);
      check("lit_maxlen1_ferr", 32'(obs_ferr), 1);
      clear_obs();
      send_frame(2, 16390, -1, 1'b0, -1);
      check("lit_sat_len", 32'(obs_flen), 16383);

      for (int t = 0; t < 300; t++) begin
         kind = $urandom_range(0, 9);
         case (kind)
            0, 1, 2: idle_burst();
            3, 4:    send_frame($urandom_range(1, 7), $urandom_range(0, 80), -1, 1'b1, -1);
            5: begin
               do b = 8'($urandom); while (b == 8'h55);
               drop_frame(b, $urandom_range(0, 8));
            end
            6: pre_bad($urandom_range(1, 7), $urandom_range(0, 6));
            7: pre_abort($urandom_range(1, 7));
            8: begin
               len = $urandom_range(1, 80);
               send_frame($urandom_range(1, 7), len, $urandom_range(0, len - 1), 1'b0, -1);
            end
            default: begin
               if ($urandom_range(0, 3) == 0) begin
                  len = $urandom_range(10, 40);
                  send_frame($urandom_range(1, 7), len, -1, 1'b1, $urandom_range(0, len - 1));
                  do_reset();
                  hold_phase(1'b0);
               end else begin
                  idle_burst();
               end
            end
         endcase
      end

      check("queue_drained", 32'(expq.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
